// File: rtl/onectr_ctrl_pkg.sv
// Shared types for the one-counter control unit: FSM states, ALU opcodes,
// register-write source codes and the fixed register allocation.
package onectr_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOAD  = 4'd1,
    CLR   = 4'd2,
    ONE   = 4'd3,
    TEST  = 4'd4,
    INC   = 4'd5,
    SHIFT = 4'd6,
    DONE  = 4'd7,
    ERR   = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    OP_PASSA = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_SHR   = 3'b101,
    OP_SHL   = 3'b110,
    OP_ZERO  = 3'b111
  } alu_op_t;

  typedef enum logic [3:0] {
    WSEL_ALU    = 4'd0,
    WSEL_INPORT = 4'd1,
    WSEL_ONE    = 4'd2
  } wsel_t;

  localparam logic [3:0] R_OPND = 4'd0;
  localparam logic [3:0] R_CNT  = 4'd1;
  localparam logic [3:0] R_ONE  = 4'd2;

endpackage

// File: rtl/onectr_ctrl_fsm.sv
// Hardwired sequencer that counts set bits of the datapath input word by
// test/increment/shift loops, then drives the count onto the output port.
module onectr_ctrl_fsm
  import onectr_ctrl_pkg::*;
#(
  parameter int INPUTSIZE = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       zero_i,
  input  logic       lsb_i,
  output logic [3:0] Sel,
  output logic       Wen,
  output logic [3:0] WA,
  output logic [3:0] RAA,
  output logic [3:0] RAB,
  output logic [2:0] Op,
  output logic       out_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int ITW = $clog2(INPUTSIZE + 1);
  localparam logic [ITW-1:0] ITER_MAX = ITW'(INPUTSIZE);

  state_t         state_q, state_d;
  logic [ITW-1:0] iter_q, iter_d;
  wsel_t          sel_c;
  alu_op_t        op_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Flags come straight from the datapath ALU in the same cycle; the
  // iteration guard only matters if zero_i never rises.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE:  if (start_i) state_d = LOAD;
      LOAD:  state_d = CLR;
      CLR:   state_d = ONE;
      ONE: begin
        iter_d  = '0;
        state_d = TEST;
      end
      TEST:  state_d = lsb_i ? INC : SHIFT;
      INC:   state_d = SHIFT;
      SHIFT: begin
        if (iter_q != ITER_MAX) iter_d = iter_q + ITW'(1);
        if (zero_i)                  state_d = DONE;
        else if (iter_d == ITER_MAX) state_d = ERR;
        else                         state_d = TEST;
      end
      DONE:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_c    = WSEL_ALU;
    op_c     = OP_PASSA;
    Wen      = 1'b0;
    WA       = 4'd0;
    RAA      = 4'd0;
    RAB      = 4'd0;
    out_en_o = 1'b0;
    done_o   = 1'b0;
    error_o  = 1'b0;
    busy_o   = (state_q != IDLE);
    case (state_q)
      LOAD: begin
        Wen   = 1'b1;
        WA    = R_OPND;
        sel_c = WSEL_INPORT;
      end
      CLR: begin
        Wen  = 1'b1;
        WA   = R_CNT;
        op_c = OP_ZERO;
      end
      ONE: begin
        Wen   = 1'b1;
        WA    = R_ONE;
        sel_c = WSEL_ONE;
      end
      TEST: begin
        RAA  = R_OPND;
        RAB  = R_ONE;
        op_c = OP_AND;
      end
      INC: begin
        Wen  = 1'b1;
        WA   = R_CNT;
        RAA  = R_CNT;
        RAB  = R_ONE;
        op_c = OP_ADD;
      end
      SHIFT: begin
        Wen  = 1'b1;
        WA   = R_OPND;
        RAA  = R_OPND;
        op_c = OP_SHR;
      end
      DONE: begin
        RAA      = R_CNT;
        out_en_o = 1'b1;
        done_o   = 1'b1;
      end
      ERR:     error_o = 1'b1;
      default: ;
    endcase
  end

  assign Sel = sel_c;
  assign Op  = op_c;

endmodule

// File: tb/tb_onectr_ctrl_fsm.sv
// Bench: FSM driving a register-file/ALU datapath model, checked each cycle
// against a run-length model derived from popcount and highest set bit.
module tb_onectr_ctrl_fsm;

  localparam int W = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       zero_i, lsb_i;
  logic [3:0] Sel, WA, RAA, RAB;
  logic       Wen;
  logic [2:0] Op;
  logic       out_en_o, busy_o, done_o, error_o;

  always #5 clk = ~clk;

  onectr_ctrl_fsm #(.INPUTSIZE(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .zero_i(zero_i), .lsb_i(lsb_i),
    .Sel(Sel), .Wen(Wen), .WA(WA), .RAA(RAA), .RAB(RAB), .Op(Op),
    .out_en_o(out_en_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  // Datapath model
  logic [W-1:0] regs [16];
  logic [W-1:0] din = '0;
  logic [W-1:0] dp_out = '0;
  logic [W-1:0] alu, opa, opb;
  bit           stuck = 1'b0;

  assign opa = regs[RAA];
  assign opb = regs[RAB];

  always_comb begin
    alu = '0;
    case (Op)
      3'b000: alu = opa;
      3'b001: alu = opa + opb;
      3'b010: alu = opa - opb;
      3'b011: alu = opa & opb;
      3'b100: alu = opa | opb;
      3'b101: alu = opa >> 1;
      3'b110: alu = opa << 1;
      default: alu = '0;
    endcase
  end

  assign zero_i = stuck ? 1'b0 : (alu == '0);
  assign lsb_i  = alu[0];

  always @(posedge clk) begin
    if (Wen) regs[WA] <= (Sel == 4'd1) ? din : (Sel == 4'd2) ? W'(1) : alu;
    if (out_en_o) dp_out <= alu;
  end

  function automatic int popcnt(input logic [W-1:0] d);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(d[i]);
    return n;
  endfunction

  function automatic int iters(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) if (d[i]) return i + 1;
    return 1;
  endfunction

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: a run occupies cycles [launch, m_end]; m_end is DONE or ERR.
  bit m_busy = 1'b0;
  bit m_err = 1'b0;
  int m_end = 0;
  int m_pop = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) m_busy = 1'b0;
      else if (m_busy) begin
        if (cyc == m_end) m_busy = 1'b0;
      end
      cyc = cyc + 1;
      if (!rst && !m_busy && start_i && cyc != m_end + 1) begin
        m_busy = 1'b1;
        m_err  = stuck;
        m_pop  = popcnt(din);
        m_end  = cyc + 3 + (stuck ? 2 * W : 2 * iters(din)) + m_pop;
      end
    end
  end

  bit chk_en = 1'b0;
  bit prev_done = 1'b0;
  int prev_pop = 0;

  initial begin
    bit exp_done, exp_err;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_done = m_busy && !m_err && (cyc == m_end);
        exp_err  = m_busy && m_err && (cyc == m_end);
        chk("busy", 64'(busy_o), 64'(m_busy));
        chk("done", 64'(done_o), 64'(exp_done));
        chk("out_en", 64'(out_en_o), 64'(exp_done));
        chk("error", 64'(error_o), 64'(exp_err));
        if (!m_busy) chk("idle_ctrl", 64'({Sel, Wen, WA, RAA, RAB, Op}), 64'd0);
        if (prev_done) chk("outport", dp_out, 64'(prev_pop));
        prev_done = exp_done;
        prev_pop  = m_pop;
      end
    end
  end

  task automatic run_one(input logic [W-1:0] d, input bit stk, input int pulse_at,
                         output int lat, output bit got_err, output int nbusy);
    int e;
    @(negedge clk);
    din = d; stuck = stk; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    e = cyc;
    lat = -1; got_err = 1'b0; nbusy = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy_o) nbusy++;
      if (done_o || error_o) begin
        lat = cyc + 1 - e;
        got_err = error_o;
        break;
      end
      start_i = (i == pulse_at);
      @(negedge clk);
    end
    start_i = 1'b0;
    if (lat < 0) begin
      n_chk++; n_err++;
      $display("FAIL timeout: no done/error within 400 cycles for input %0h", d);
    end
    @(negedge clk);
    stuck = 1'b0;
  endtask

  initial begin
    int lat, nb, d1, d2;
    bit ge, seen;
    logic [W-1:0] d;
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, nd, dc [4];
    bit ge, seen;
    logic [W-1:0] d;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 64'(busy_o), 64'd0);

    run_one(64'd0, 1'b0, -1, lat, ge, nb);
    chk("lat_in0", 64'(lat), 64'd6);
    chk("out_in0", dp_out, 64'd0);
    run_one(64'd1, 1'b0, -1, lat, ge, nb);
    chk("lat_in1", 64'(lat), 64'd7);
    chk("out_in1", dp_out, 64'd1);
    run_one(64'h5, 1'b0, -1, lat, ge, nb);
    chk("lat_in5", 64'(lat), 64'd12);
    chk("out_in5", dp_out, 64'd2);
    run_one({W{1'b1}}, 1'b0, -1, lat, ge, nb);
    chk("lat_ones", 64'(lat), 64'd196);
    chk("out_ones", dp_out, 64'd64);
    chk("busy_ones", 64'(nb), 64'd196);

    run_one(64'd0, 1'b1, -1, lat, ge, nb);
    chk("lat_stuck", 64'(lat), 64'd132);
    chk("err_stuck", 64'(ge), 64'd1);

    run_one(64'h5, 1'b0, 4, lat, ge, nb);
    chk("lat_pulse", 64'(lat), 64'd12);
    chk("out_pulse", dp_out, 64'd2);

    // Reset during a TEST cycle
    @(negedge clk);
    din = 64'hFF; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (Op == 3'b011 && !Wen) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL rst_test: TEST state not observed");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ctrl", 64'({Sel, Wen, WA, RAA, RAB, Op, out_en_o, done_o, error_o}), 64'd0);
    repeat (10) @(negedge clk);
    run_one(64'h5, 1'b0, -1, lat, ge, nb);
    chk("lat_after_rst", 64'(lat), 64'd12);

    // start_i held high: back-to-back runs
    @(negedge clk);
    din = 64'h5; start_i = 1'b1;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_o && nd < 4) begin
        dc[nd] = cyc;
        nd++;
      end
    end
    start_i = 1'b0;
    chk("b2b_runs", 64'(nd), 64'd4);
    if (nd >= 3) begin
      chk("b2b_gap0", 64'(dc[1] - dc[0]), 64'd13);
      chk("b2b_gap1", 64'(dc[2] - dc[1]), 64'd13);
    end
    repeat (20) @(negedge clk);

    // Randomised runs
    for (int r = 0; r < 30; r++) begin
      d = {$urandom, $urandom};
      d = d >> $urandom_range(63, 0);
      if (r % 10 == 0) d = '0;
      run_one(d, 1'b0, int'($urandom_range(40, 0)), lat, ge, nb);
      chk("lat_rand", 64'(lat), 64'(4 + 2 * iters(d) + popcnt(d)));
      chk("out_rand", dp_out, 64'(popcnt(d)));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/onectr_ctrl_fsm.md
# onectr_ctrl_fsm

Hardwired control unit for the one-counter register-file/ALU datapath. On `start_i` it sequences register writes, ALU operations and flag tests that count the set bits of the datapath input word. It then requests the result onto the output port and reports completion. It replaces the program-memory sequencer with a fixed state machine and drives the same control fields (`Sel`, `Wen`, `WA`, `RAA`, `RAB`, `Op`) the datapath already decodes.

## Interface
Parameters:
- `INPUTSIZE`, 64: datapath word width; bounds the shift-loop iteration count.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `start_i`  in  1: begin a count; sampled only in IDLE.
- `zero_i`  in  1: datapath flag; the current ALU result equals 0 (combinational, same cycle).
- `lsb_i`  in  1: datapath flag; bit 0 of the current ALU result (combinational, same cycle).
- `Sel`  out  4: register write source. 0 = ALU, 1 = `InPort`, 2 = constant 1.
- `Wen`  out  1: register file write enable.
- `WA`  out  4: write address.
- `RAA`  out  4: read address A.
- `RAB`  out  4: read address B.
- `Op`  out  3: ALU op. 000 passA, 001 A+B, 010 A−B, 011 A&B, 100 A|B, 101 A>>1, 110 A<<1, 111 zero.
- `out_en_o`  out  1: datapath latches the ALU result into `OutPort`.
- `busy_o`  out  1: high in every state except IDLE.
- `done_o`  out  1: one-cycle pulse on successful completion.
- `error_o`  out  1: one-cycle pulse when the iteration guard trips.

## Operation
- Register allocation:
  - R0 = shifting operand.
  - R1 = count.
  - R2 = constant 1.
- States and outputs (all unlisted outputs are 0):
  - IDLE: if `start_i` is high, go to LOAD.
  - LOAD: `Wen`=1, `WA`=0, `Sel`=1. Go to CLR.
  - CLR: `Wen`=1, `WA`=1, `Sel`=0, `Op`=111. Go to ONE.
  - ONE: `Wen`=1, `WA`=2, `Sel`=2. Clear the iteration counter. Go to TEST.
  - TEST: `RAA`=0, `RAB`=2, `Op`=011, `Wen`=0. If `lsb_i` is high, go to INC; otherwise go to SHIFT.
  - INC: `Wen`=1, `WA`=1, `RAA`=1, `RAB`=2, `Op`=001, `Sel`=0. Go to SHIFT.
  - SHIFT: `Wen`=1, `WA`=0, `RAA`=0, `Op`=101, `Sel`=0. Increment the iteration counter.
    - If `zero_i` is high, go to DONE.
    - Else if the counter has reached `INPUTSIZE`, go to ERR.
    - Else go to TEST.
  - DONE: `RAA`=1, `Op`=000, `out_en_o`=1, `done_o`=1. Go to IDLE.
  - ERR: `error_o`=1, no write. Go to IDLE.
- Iteration counter is `$clog2(INPUTSIZE+1)` bits wide. It saturates; it never wraps.
- `start_i` is ignored while `busy_o` is high. A `start_i` held high re-launches from IDLE on the cycle after DONE/ERR.
- The block stores no data; all values stay in the datapath.

## Timing
- Reset: state = IDLE and iteration counter = 0. All outputs are 0 in the cycle after `rst` is sampled high.
- Reset mid-operation aborts the run immediately, with no `done_o` or `error_o`.
- `start_i` sampled high at edge k puts the FSM in LOAD during cycle k+1.
- Iterations N = index of the highest set bit + 1 (N = 1 for input 0). Ones P = popcount.
- `done_o` is high during cycle k + 4 + 2N + P. `out_en_o` is high in the same cycle.
- `busy_o` is high from cycle k+1 through the DONE/ERR cycle inclusive.
- Flags are consumed in the same cycle the ALU produces them, so there is no flag register in this block.
- With a correct datapath, ERR is unreachable. It exists only as a livelock guard against a stuck `zero_i`.

## Structure
- Package `onectr_ctrl_pkg` holds:
  - `state_t` enum (IDLE, LOAD, CLR, ONE, TEST, INC, SHIFT, DONE, ERR).
  - `alu_op_t` with the eight opcodes.
  - `wsel_t` source codes.
  - localparams for register indices R_OPND=0, R_CNT=1, R_ONE=2.
- Single module. The state register and counter live in one `always_ff`. Output decode is one `always_comb` keyed on state with defaults first.
- No sub-module.

## Test plan
- Reset: assert `rst` mid-run (during TEST) → next cycle all outputs are 0 and IDLE. No `done_o` follows. A later start runs normally.
- Input 0: start at edge k → `done_o` in cycle k+6, `out_en_o` coincident; the datapath model's `OutPort` = 0.
- Input 1: `done_o` in cycle k+7, `OutPort` = 1. Input 0x5 (N=3, P=2): `done_o` at k+12, `OutPort` = 2.
- Input all-ones at INPUTSIZE=64: `done_o` at k+196, `OutPort` = 64. `busy_o` is high for 196 consecutive cycles.
- Stuck flag: force `zero_i`=0 with input 0 → `error_o` pulses after the 64th SHIFT, then IDLE. `done_o` never asserts.
- `start_i` pulsed while busy → ignored, and the count and latency are unchanged. `start_i` held constantly high → back-to-back runs, each LOAD occurring in the cycle after DONE's following IDLE cycle.
